// File: rtl/adder_seq_pkg.sv
// rtl/adder_seq_pkg.sv - shared state encoding, mode codes and widths for the nibble-sequenced adder
package adder_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int WIDTH_DEF = 8;
    localparam int NIB_DEF   = 4;

endpackage

// File: rtl/nibble_adder.sv
// rtl/nibble_adder.sv - combinational NIB-bit adder with carry in/out
module nibble_adder
    import adder_seq_pkg::*;
#(
    parameter int NIB = NIB_DEF
) (
    input  logic [NIB-1:0] a,
    input  logic [NIB-1:0] b,
    input  logic           cin,
    output logic [NIB-1:0] s,
    output logic           cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIB{1'b0}}, cin};

endmodule

// File: rtl/adder_arbiter_seq.sv
// rtl/adder_arbiter_seq.sv - round-robin sharing of one nibble adder for 8-bit add/sub, two passes per op
module adder_arbiter_seq
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NIB   = NIB_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             m0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             m1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    state_t           state;
    logic             last;
    logic             w_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] beff_r;
    logic             m_r;
    logic [NIB-1:0]   s_lo;
    logic             c_r;

    logic             win;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             m_sel;

    logic [NIB-1:0]   nib_a;
    logic [NIB-1:0]   nib_b;
    logic             nib_cin;
    logic [NIB-1:0]   nib_s;
    logic             nib_c;

    // On a tie the requester not served last wins; a single request wins outright.
    always_comb begin
        win = 1'b0;
        if (req == 2'b11)
            win = ~last;
        else
            win = req[1];
        a_sel = win ? a1 : a0;
        b_sel = win ? b1 : b0;
        m_sel = win ? m1 : m0;
    end

    // Low pass seeds the carry with the mode bit (two's complement +1 for subtract).
    always_comb begin
        nib_a   = '0;
        nib_b   = '0;
        nib_cin = 1'b0;
        if (state == ST_LO) begin
            nib_a   = a_r[NIB-1:0];
            nib_b   = beff_r[NIB-1:0];
            nib_cin = m_r;
        end else begin
            nib_a   = a_r[WIDTH-1:NIB];
            nib_b   = beff_r[WIDTH-1:NIB];
            nib_cin = c_r;
        end
    end

    nibble_adder #(.NIB(NIB)) u_nib (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (nib_cin),
        .s    (nib_s),
        .cout (nib_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            gnt    <= '0;
            done   <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            last   <= 1'b1;
            w_r    <= 1'b0;
            a_r    <= '0;
            beff_r <= '0;
            m_r    <= MODE_ADD;
            s_lo   <= '0;
            c_r    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= '0;
                    if (req != 2'b00) begin
                        w_r    <= win;
                        a_r    <= a_sel;
                        beff_r <= (m_sel == MODE_SUB) ? ~b_sel : b_sel;
                        m_r    <= m_sel;
                        gnt    <= win ? 2'b10 : 2'b01;
                        busy   <= 1'b1;
                        state  <= ST_LO;
                    end
                end
                ST_LO: begin
                    s_lo  <= nib_s;
                    c_r   <= nib_c;
                    state <= ST_HI;
                end
                ST_HI: begin
                    result <= {nib_s, s_lo};
                    cout   <= nib_c;
                    ovf    <= (a_r[WIDTH-1] == beff_r[WIDTH-1]) && (nib_s[NIB-1] != a_r[WIDTH-1]);
                    done   <= w_r ? 2'b10 : 2'b01;
                    last   <= w_r;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= '0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= '0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/adder_arbiter_seq.md
Name: adder_arbiter_seq

Overview:
- Shares one 4-bit add/subtract nibble datapath between two requesters.
- Executes each granted 8-bit add or subtract as two nibble passes: low nibble first, then high nibble with the chained carry.
- Round-robin arbitration; operands are latched at grant, so requesters need not hold them.
- Sits between ALU front-end requesters and the nibble adder; it is the sole sequencer of that adder.

Parameters:
- WIDTH, 8, operand/result width; must equal 2*NIB.
- NIB, 4, nibble adder width; fixed by the shared datapath.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  2  request level per requester; sampled only in IDLE.
- a0  in  WIDTH  requester 0 operand A.
- b0  in  WIDTH  requester 0 operand B.
- m0  in  1  requester 0 mode: 0 add, 1 subtract (A-B).
- a1  in  WIDTH  requester 1 operand A.
- b1  in  WIDTH  requester 1 operand B.
- m1  in  1  requester 1 mode.
- gnt  out  2  one-hot grant, registered; high from the cycle after acceptance through the done cycle.
- done  out  2  one-cycle pulse to the granted requester when the result is valid.
- result  out  WIDTH  sum/difference; held until the next done.
- cout  out  1  carry out of MSB; for subtract, 1 = no borrow (A>=B unsigned).
- ovf  out  1  signed overflow of the operation.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - gnt=0, done=0, result=0, cout=0, ovf=0, busy=0.
  - Priority pointer set so requester 0 wins the first tie.
  - Internal nibble/carry registers cleared.
  - Reset overrides any in-flight operation; no done is issued for it.
- States: IDLE -> LO -> HI -> DONE -> IDLE. No other transitions. Any illegal encoding goes to IDLE.
- IDLE:
  - If req==0, stay.
  - Otherwise pick the winner:
    - only one bit set -> that requester;
    - both set -> the requester not served last (pointer).
  - Latch a_w, b_w and m_w; form beff = m ? ~b : b.
  - Set gnt[w]=1 and go to LO.
- LO:
  - Nibble adder computes a[3:0] + beff[3:0] + cin, with cin = m.
  - Store s[3:0] and the carry; go to HI.
- HI:
  - Nibble adder computes a[7:4] + beff[7:4] + stored carry.
  - Register result = {s_hi, s_lo} and cout = carry out.
  - ovf = (a[7] == beff[7]) && (result[7] != a[7]).
  - Set done[w]=1, update pointer to w, go to DONE.
- DONE:
  - done[w] high for exactly this cycle; gnt[w] still high.
  - At the next edge: done=0, gnt=0, go to IDLE.
- Latency and throughput:
  - Request sampled at edge N; done high in the cycle after edge N+2.
  - Next acceptance no earlier than edge N+4, so at most one op per 4 cycles.
- Requester rules:
  - A requester wanting only one op drops req by the edge after done.
  - A req still high in IDLE starts a new op.
- Fairness: with both req held high, grants alternate 0,1,0,1...
- Stability: result/cout/ovf change only on the HI->DONE edge or reset. Operand changes after acceptance have no effect.
- The nibble adder is the only arithmetic resource; it is used once in LO and once in HI.

Decomposition:
- Shared package (adder_seq_pkg):
  - state encoding IDLE/LO/HI/DONE;
  - MODE_ADD=0, MODE_SUB=1;
  - WIDTH/NIB defaults.
- One sub-module, nibble_adder:
  - combinational NIB-bit a + b + cin -> s, cout;
  - instantiated once;
  - the subtract inversion is done in the controller, not in the sub-module.

Test Plan:
- Add: req=01, a0=0x3A, b0=0x47, m0=0 -> done[0] three cycles later with result=0x81, cout=0, ovf=1; gnt=01 during LO..DONE.
- Nibble carry: a1=0x0F, b1=0x01, add -> result=0x10, cout=0, ovf=0.
- Wrap: 0xFF+0x01 -> result=0x00, cout=1, ovf=0.
- Subtract:
  - 0x10-0x01 -> 0x0F, cout=1, ovf=0;
  - 0x80-0x01 -> 0x7F, cout=1, ovf=1;
  - 0x01-0x02 -> 0xFF, cout=0, ovf=0.
- Arbitration: after reset hold req=11 -> grant order 0,1,0,1 with done pulses every 4 cycles; each result matches its own operands. Changing a0 after its grant does not alter its result.
- Reset mid-op: rst_n=0 for one edge while state=HI -> next cycle gnt=0, done=0, busy=0, result=0; no done pulse for the aborted op; next tie goes to requester 0.
